// File: rtl/scancode_event_decoder.sv
// scancode_event_decoder
//   Turns the PS/2 scan-code byte stream into key events {code, break, ext}.
//   E0 (extended) and F0 (break) prefixes are tracked by a small FSM, and
//   completed events are queued in a first-word-fall-through FIFO drained
//   through a valid/ready handshake.
//   Optional feature macro: TYPEMATIC_FILTER_EN adds a held-key register that
//   suppresses repeated make events caused by keyboard auto-repeat.
module scancode_event_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          scan_valid,
  input  logic [7:0]                    scan_code,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_break,
  output logic                          evt_ext,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic            w_gen;
  logic            w_gen_brk;
  logic            w_gen_ext;
  logic            w_suppress;
  logic            w_push_req;
  logic            w_push_ok;
  logic            w_pop;
  logic            w_full;
  logic            w_is_prefix;

  logic [9:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_count;
  logic            r_overflow;

  assign w_is_prefix = (scan_code == CODE_EXT) || (scan_code == CODE_BRK);

  // Prefix-tracking state register; a reset discards any partial prefix
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: moves only on strobed bytes; E0 always restarts as extended
  always_comb begin
    w_next_state = r_state;
    if (scan_valid) begin
      if (scan_code == CODE_EXT) begin
        w_next_state = EXT;
      end else if (scan_code == CODE_BRK) begin
        case (r_state)
          IDLE, BRK:    w_next_state = BRK;
          EXT, EXT_BRK: w_next_state = EXT_BRK;
          default:      w_next_state = BRK;
        endcase
      end else begin
        w_next_state = IDLE;
      end
    end
  end

  // Event generation: a non-prefix byte completes an event flagged by the current state
  always_comb begin
    w_gen     = 1'b0;
    w_gen_brk = 1'b0;
    w_gen_ext = 1'b0;
    if (scan_valid && !w_is_prefix) begin
      w_gen     = 1'b1;
      w_gen_brk = (r_state == BRK) || (r_state == EXT_BRK);
      w_gen_ext = (r_state == EXT) || (r_state == EXT_BRK);
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  logic [7:0] r_held_code;
  logic       r_held_ext;
  logic       r_held_valid;
  logic       w_held_match;

  assign w_held_match = r_held_valid && (r_held_code == scan_code) &&
                        (r_held_ext == w_gen_ext);
  assign w_suppress   = w_gen && !w_gen_brk && w_held_match;

  // Held-key tracking: every make reloads it, a matching break releases it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_held_code  <= 8'h00;
      r_held_ext   <= 1'b0;
      r_held_valid <= 1'b0;
    end else if (w_gen && !w_gen_brk) begin
      r_held_code  <= scan_code;
      r_held_ext   <= w_gen_ext;
      r_held_valid <= 1'b1;
    end else if (w_gen && w_gen_brk && w_held_match) begin
      r_held_valid <= 1'b0;
    end
  end
`else
  assign w_suppress = 1'b0;
`endif

  assign w_push_req = w_gen && !w_suppress;
  assign w_full     = (r_count == FULL_LVL);
  assign w_pop      = evt_valid && evt_ready;
  assign w_push_ok  = w_push_req && (!w_full || w_pop);

  // Event storage; no reset needed because the outputs are gated by evt_valid
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= {scan_code, w_gen_brk, w_gen_ext};
    end
  end

  // FIFO pointers and occupancy; a push into a full FIFO needs a same-cycle pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push_ok && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Sticky drop flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_push_req && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  assign evt_valid  = (r_count != '0);
  assign evt_code   = evt_valid ? r_mem[r_rd_ptr][9:2] : 8'h00;
  assign evt_break  = evt_valid ? r_mem[r_rd_ptr][1]   : 1'b0;
  assign evt_ext    = evt_valid ? r_mem[r_rd_ptr][0]   : 1'b0;
  assign fifo_level = r_count;
  assign overflow   = r_overflow;

endmodule
